// File: rtl/d3s_adc_decim_packer.sv
// Boxcar decimator for the D3S ADC: averages 2^k samples and packs two 16-bit averages per 32-bit word.
// Optional macro D3S_ADC_DECIM_SEQ_TAG_EN adds an 8-bit word sequence tag (out_seq_o).
module d3s_adc_decim_packer #(
    parameter int g_SAMPLE_WIDTH   = 14,
    parameter int g_MAX_DECIM_LOG2 = 7
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_n_i,
    input  logic                      enable_i,
    input  logic [2:0]                decim_log2_i,
    input  logic [g_SAMPLE_WIDTH-1:0] adc_data_i,
    input  logic                      adc_valid_i,
    output logic [31:0]               out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      overflow_o,
    input  logic                      clr_overflow_i
`ifdef D3S_ADC_DECIM_SEQ_TAG_EN
    ,
    output logic [7:0]                out_seq_o
`endif
);

    localparam int         AW    = g_SAMPLE_WIDTH + g_MAX_DECIM_LOG2;
    localparam int         CW    = g_MAX_DECIM_LOG2 + 1;
    localparam logic [2:0] K_MAX = 3'(g_MAX_DECIM_LOG2);

    logic signed [AW-1:0]             acc_q, acc_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [2:0]                       k_q, k_d;
    logic                             half_vld_q, half_vld_d;
    logic [15:0]                      half_q, half_d;
    logic [31:0]                      out_data_q, out_data_d;
    logic                             out_valid_q, out_valid_d;
    logic                             ovf_q, ovf_d;

    logic                             sample_en;
    logic [2:0]                       k_win;
    logic signed [g_SAMPLE_WIDTH-1:0] sample_s;
    logic signed [AW-1:0]             sum;
    logic signed [AW-1:0]             sum_sh;
    logic [CW-1:0]                    win_len;
    logic [CW-1:0]                    cnt_inc;
    logic                             win_done;
    logic [15:0]                      avg16;
    logic                             word_done;
    logic [31:0]                      word;
    logic                             load;
    logic                             drop;

    // Stream handshake: a word transfers on any rising edge where out_valid_o=1 and
    // out_ready_i=1; while out_valid_o=1 and out_ready_i=0 data and valid hold still.
    always_comb begin
        sample_en = enable_i && adc_valid_i;
        // k only follows the input at the start of a window
        if (cnt_q == '0) begin
            k_win = (decim_log2_i > K_MAX) ? K_MAX : decim_log2_i;
        end else begin
            k_win = k_q;
        end
        sample_s  = adc_data_i;
        sum       = acc_q + AW'(sample_s);
        sum_sh    = sum >>> k_win;
        win_len   = CW'(1) << k_win;
        cnt_inc   = cnt_q + CW'(1);
        win_done  = sample_en && (cnt_inc == win_len);
        // The average always fits the sample range, so a plain 16-bit resize is exact
        avg16     = 16'(sum_sh);
        word_done = win_done && half_vld_q;
        word      = {avg16, half_q};
        load      = word_done && (!out_valid_q || out_ready_i);
        drop      = word_done && !load;
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        half_vld_d = half_vld_q;
        half_d     = half_q;
        if (!enable_i) begin
            acc_d      = '0;
            cnt_d      = '0;
            half_vld_d = 1'b0;
        end else if (adc_valid_i) begin
            k_d = k_win;
            if (win_done) begin
                acc_d = '0;
                cnt_d = '0;
                if (half_vld_q) begin
                    half_vld_d = 1'b0;
                end else begin
                    half_d     = avg16;
                    half_vld_d = 1'b1;
                end
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
            end
        end

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_data_d  = word;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        // A drop in the same cycle as a clear keeps the flag set
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            half_vld_q  <= 1'b0;
            half_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            half_vld_q  <= half_vld_d;
            half_q      <= half_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign overflow_o  = ovf_q;

`ifdef D3S_ADC_DECIM_SEQ_TAG_EN
    logic [7:0] seq_cnt_q, seq_cnt_d;
    logic [7:0] out_seq_q, out_seq_d;

    // Dropped words also consume a tag so the consumer can see the gap
    always_comb begin
        seq_cnt_d = word_done ? (seq_cnt_q + 8'd1) : seq_cnt_q;
        out_seq_d = load ? seq_cnt_q : out_seq_q;
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seq_cnt_q <= '0;
            out_seq_q <= '0;
        end else begin
            seq_cnt_q <= seq_cnt_d;
            out_seq_q <= out_seq_d;
        end
    end

    assign out_seq_o = out_seq_q;
`endif

endmodule

// File: doc/d3s_adc_decim_packer.md
Name: d3s_adc_decim_packer

Overview:
- Sits directly downstream of the D3S ADC sample interface, upstream of the node CPU sample queue.
- Averages each block of 2^k consecutive valid ADC samples (boxcar decimation).
- Packs two 16-bit averaged samples into one 32-bit word.
- Presents words on a valid/ready stream; overruns are flagged in a sticky status bit readable by the CPU.

Parameters:
- g_SAMPLE_WIDTH, 14: ADC sample width; samples are signed two's complement; must be 8..16.
- g_MAX_DECIM_LOG2, 7: largest accepted decimation exponent k; accumulator width = g_SAMPLE_WIDTH + g_MAX_DECIM_LOG2.

Ports:
- clk_sys_i  in  1  system clock; the only clock in the block.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- enable_i  in  1  run enable; low holds the datapath idle.
- decim_log2_i  in  3  exponent k, N = 2^k; values above g_MAX_DECIM_LOG2 are clamped to it.
- adc_data_i  in  g_SAMPLE_WIDTH  signed ADC sample.
- adc_valid_i  in  1  qualifies adc_data_i for one cycle.
- out_data_o  out  32  packed word: [15:0] = older average, [31:16] = newer average.
- out_valid_o  out  1  word available.
- out_ready_i  in  1  consumer accepts the word when out_valid_o=1 and out_ready_i=1.
- overflow_o  out  1  sticky flag: at least one word was dropped.
- clr_overflow_i  in  1  single-cycle pulse that clears overflow_o.

Behaviour:
- Reset values: out_data_o=0, out_valid_o=0, overflow_o=0; accumulator, sample counter, half-word flag and latched k are all cleared.
- Accumulation window:
  - k is latched from decim_log2_i at the first valid sample of each window, when the sample counter is 0.
  - Changing decim_log2_i mid-window has no effect until the next window.
- Accumulation:
  - Each cycle with enable_i=1 and adc_valid_i=1 adds the sign-extended sample to the accumulator and increments the counter.
  - On the 2^k-th sample, avg = (acc + sample) arithmetic-shift-right by k.
  - avg is then sign-extended or truncated to 16 bits. It never exceeds the sample range, so saturation is never needed.
  - The accumulator and counter restart from 0 in the same cycle.
- k=0: every valid sample is itself an average.
- Packing:
  - The first average of a pair is held in a 16-bit half register.
  - The second average completes the word as {second, first}.
- Word completion and handshake:
  - The completed word is registered. out_valid_o rises on the clock edge after the adc_valid_i cycle that completed it, so latency is 1 cycle.
  - If out_valid_o=0, or a handshake occurs in that same cycle, the new word loads and out_valid_o=1.
  - If out_valid_o=1 and out_ready_i=0, the new word is dropped, the held word is unchanged and overflow_o is set.
- Stream stability: out_data_o and out_valid_o stay stable while out_valid_o=1 and out_ready_i=0. out_valid_o falls the cycle after the handshake unless a new word loads on that edge.
- Overflow clear vs set: clr_overflow_i in the same cycle as a new drop leaves overflow_o=1 (set wins).
- enable_i low:
  - Accumulator, counter and half-word flag are cleared, so partial data is discarded.
  - adc_valid_i is ignored.
  - A pending output word is still held until it is accepted.
- Re-enable: the first valid sample starts a fresh window and the first half of a new word.
- Reset asserted mid-operation: all state clears immediately, including the pending word. No output is produced until at least 2·2^k valid samples arrive after the release.

Optional Feature:
- Macro: D3S_ADC_DECIM_SEQ_TAG_EN.
- When defined:
  - Adds output port out_seq_o (8 bits, reset 0).
  - Each loaded word carries the value of an internal word counter, which then increments and wraps 255→0.
  - The counter also increments for dropped words, so the consumer can detect gaps.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- k=0, enable=1, out_ready=1, samples 1,2,3,4 on consecutive cycles → words 0x00020001 then 0x00040003. Each has out_valid_o high the cycle after the 2nd/4th sample.
- k=2, samples -8,-8,-8,-8 then 100,100,100,104 → one word 0x0065FFF8 (avg -8 and 101).
- k=0, out_ready=0, six samples → first word held unchanged, overflow_o=1. Then ready=1 → only the first word is delivered. clr_overflow_i pulse → overflow_o=0.
- k=1, three samples then enable=0 for 2 cycles then re-enable with samples 10,10,20,20 → word 0x0014000A only; the partial data is discarded.
- Change decim_log2_i from 1 to 3 after the first sample of a window → that window still averages 2 samples; the next window averages 8.
- With D3S_ADC_DECIM_SEQ_TAG_EN, 258 words at ready=1 → out_seq_o runs 0..255,0,1. Force one drop → the next accepted word's tag skips by 2.
